// File: rtl/face_cmd_dispatcher.sv
// Instruction front-end for the Frodo engine: a valid/ready FIFO whose head is
// decoded in order into SETBASE / START / FENCE actions on NUM_ENG engines.
module face_cmd_dispatcher #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         NUM_ENG    = 2,
    parameter int         NUM_BASE   = 4,
    parameter int         ADDR_W     = 32,
    parameter logic [6:0] OPC_BASE   = 7'h0B
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                instr_valid,
    input  logic [31:0]                         instr,
    output logic                                instr_ready,
    output logic [NUM_ENG-1:0]                  eng_start,
    output logic [NUM_ENG*2-1:0]                eng_mode,
    output logic [NUM_ENG*19-1:0]               eng_arg,
    output logic [NUM_ENG*NUM_BASE*ADDR_W-1:0]  eng_base,
    input  logic [NUM_ENG-1:0]                  eng_done,
    output logic [NUM_ENG-1:0]                  eng_busy,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic                                busy,
    output logic                                err_illegal,
    input  logic                                err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int EW    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    localparam logic [2:0] FUNC_SETBASE = 3'b000;
    localparam logic [2:0] FUNC_START   = 3'b001;
    localparam logic [2:0] FUNC_FENCE   = 3'b010;

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [NUM_ENG-1:0] start_q, start_d, ebusy_q, ebusy_d;
    logic [1:0]        mode_q [NUM_ENG];
    logic [1:0]        mode_d [NUM_ENG];
    logic [18:0]       arg_q  [NUM_ENG];
    logic [18:0]       arg_d  [NUM_ENG];
    logic [ADDR_W-1:0] base_q [NUM_ENG][NUM_BASE];
    logic [ADDR_W-1:0] base_d [NUM_ENG][NUM_BASE];
    logic              err_q, err_d;

    logic        full, empty, push, pop;
    logic [31:0] head;
    logic [6:0]  opcode;
    logic [2:0]  func;
    logic [1:0]  sel;
    logic [18:0] payload;
    logic [7:0]  opc_off;
    logic [EW-1:0] eidx;
    logic        opc_ok, sel_ok, tgt_busy;
    logic        do_setbase, do_start, do_fence, illegal;
    logic        unused_bits;

    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign push    = instr_valid && !full;

    assign head    = mem_q[rd_ptr_q];
    assign opcode  = head[6:0];
    assign func    = head[9:7];
    assign sel     = head[11:10];
    assign payload = head[30:12];
    assign unused_bits = head[31];

    // Opcodes below OPC_BASE wrap to a large offset and fail the range test too.
    assign opc_off = {1'b0, opcode} - {1'b0, OPC_BASE};
    assign opc_ok  = (opcode >= OPC_BASE) && (opc_off < 8'(NUM_ENG));
    assign eidx    = opc_off[EW-1:0];
    assign sel_ok  = ({1'b0, sel} < 3'(NUM_BASE));

    always_comb begin
        tgt_busy   = 1'b0;
        do_setbase = 1'b0;
        do_start   = 1'b0;
        do_fence   = 1'b0;
        illegal    = 1'b0;
        for (int e = 0; e < NUM_ENG; e++) begin
            if (eidx == EW'(e)) tgt_busy = ebusy_q[e];
        end
        if (!empty) begin
            if (!opc_ok) begin
                illegal = 1'b1;
            end else begin
                case (func)
                    FUNC_SETBASE: begin
                        if (!sel_ok)        illegal    = 1'b1;
                        else if (!tgt_busy) do_setbase = 1'b1;
                    end
                    FUNC_START:   if (!tgt_busy) do_start = 1'b1;
                    FUNC_FENCE:   if (ebusy_q == '0 && start_q == '0) do_fence = 1'b1;
                    default:      illegal = 1'b1;
                endcase
            end
        end
        pop = illegal | do_setbase | do_start | do_fence;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        err_d    = illegal ? 1'b1 : (err_clr ? 1'b0 : err_q);
        start_d  = '0;
        mode_d   = mode_q;
        arg_d    = arg_q;
        base_d   = base_q;
        for (int e = 0; e < NUM_ENG; e++) begin
            if (eidx == EW'(e)) begin
                if (do_start) begin
                    start_d[e] = 1'b1;
                    mode_d[e]  = sel;
                    arg_d[e]   = payload;
                end
                for (int s = 0; s < NUM_BASE; s++) begin
                    if (do_setbase && sel == 2'(s)) base_d[e][s] = ADDR_W'(payload);
                end
            end
        end
        // A START can never pop while its engine is busy, so set and clear never collide.
        ebusy_d = (ebusy_q & ~eng_done) | start_d;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            start_q  <= '0;
            ebusy_q  <= '0;
            err_q    <= 1'b0;
            for (int e = 0; e < NUM_ENG; e++) begin
                mode_q[e] <= '0;
                arg_q[e]  <= '0;
                for (int s = 0; s < NUM_BASE; s++) base_q[e][s] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            start_q  <= start_d;
            ebusy_q  <= ebusy_d;
            err_q    <= err_d;
            mode_q   <= mode_d;
            arg_q    <= arg_d;
            base_q   <= base_d;
        end
    end

    for (genvar e = 0; e < NUM_ENG; e++) begin : g_eng
        assign eng_mode[2*e +: 2]  = mode_q[e];
        assign eng_arg[19*e +: 19] = arg_q[e];
        for (genvar s = 0; s < NUM_BASE; s++) begin : g_base
            assign eng_base[(e*NUM_BASE+s)*ADDR_W +: ADDR_W] = base_q[e][s];
        end
    end

    assign instr_ready = !full;
    assign eng_start   = start_q;
    assign eng_busy    = ebusy_q;
    assign fifo_level  = level_q;
    assign busy        = (level_q != '0) || (ebusy_q != '0);
    assign err_illegal = err_q;

endmodule

// File: tb/tb_face_cmd_dispatcher.sv
// Bench for face_cmd_dispatcher: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_face_cmd_dispatcher;

    localparam int         FIFO_DEPTH = 4;
    localparam int         NUM_ENG    = 2;
    localparam int         NUM_BASE   = 4;
    localparam int         ADDR_W     = 32;
    localparam logic [6:0] OPC_BASE   = 7'h0B;
    localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [NUM_ENG-1:0] eng_done = '0;
    logic err_clr = 1'b0;

    logic instr_ready, busy, err_illegal;
    logic [NUM_ENG-1:0] eng_start, eng_busy;
    logic [NUM_ENG*2-1:0] eng_mode;
    logic [NUM_ENG*19-1:0] eng_arg;
    logic [NUM_ENG*NUM_BASE*ADDR_W-1:0] eng_base;
    logic [LVL_W-1:0] fifo_level;

    face_cmd_dispatcher #(
        .FIFO_DEPTH(FIFO_DEPTH), .NUM_ENG(NUM_ENG), .NUM_BASE(NUM_BASE),
        .ADDR_W(ADDR_W), .OPC_BASE(OPC_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .eng_start(eng_start), .eng_mode(eng_mode),
        .eng_arg(eng_arg), .eng_base(eng_base), .eng_done(eng_done),
        .eng_busy(eng_busy), .fifo_level(fifo_level), .busy(busy),
        .err_illegal(err_illegal), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: the queue is the FIFO contents in arrival order.
    logic [31:0]       m_q[$];
    logic [NUM_ENG-1:0] m_busy, m_start;
    logic [1:0]        m_mode [NUM_ENG];
    logic [18:0]       m_arg  [NUM_ENG];
    logic [ADDR_W-1:0] m_base [NUM_ENG][NUM_BASE];
    logic              m_err;

    function automatic logic [31:0] mk(int e, logic [2:0] f, logic [1:0] s, logic [18:0] p);
        logic [6:0] opc;
        opc = 7'(int'(OPC_BASE) + e);
        return {1'b0, p, s, f, opc};
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(int e, int s);
        return eng_base[(e*NUM_BASE+s)*ADDR_W +: ADDR_W];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy  = '0;
        m_start = '0;
        m_err   = 1'b0;
        for (int e = 0; e < NUM_ENG; e++) begin
            m_mode[e] = '0;
            m_arg[e]  = '0;
            for (int s = 0; s < NUM_BASE; s++) m_base[e][s] = '0;
        end
    endtask

    // Applies one clock edge worth of spec rules to the model using current inputs.
    task automatic model_step();
        logic [31:0] w;
        logic [NUM_ENG-1:0] nstart;
        int e, s;
        logic [2:0] f;
        bit do_push, do_pop, bad;
        do_push = instr_valid && (m_q.size() < FIFO_DEPTH);
        do_pop  = 0;
        bad     = 0;
        nstart  = '0;
        if (m_q.size() > 0) begin
            w = m_q[0];
            e = int'(w[6:0]) - int'(OPC_BASE);
            f = w[9:7];
            s = int'(w[11:10]);
            if (e < 0 || e >= NUM_ENG) bad = 1;
            else if (f == 3'b000) begin
                if (s >= NUM_BASE) bad = 1;
                else if (!m_busy[e]) begin
                    do_pop = 1;
                    m_base[e][s] = ADDR_W'(w[30:12]);
                end
            end else if (f == 3'b001) begin
                if (!m_busy[e]) begin
                    do_pop = 1;
                    nstart[e] = 1'b1;
                    m_mode[e] = w[11:10];
                    m_arg[e]  = w[30:12];
                end
            end else if (f == 3'b010) begin
                if (m_busy == '0 && m_start == '0) do_pop = 1;
            end else bad = 1;
            if (bad) do_pop = 1;
        end
        m_busy  = (m_busy & ~eng_done) | nstart;
        m_start = nstart;
        if (bad) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(instr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        eng_done    = '0;
        err_clr     = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done_ok;
        done_ok = 0;
        instr_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_q.size() == 0 && m_busy == '0) begin
                done_ok = 1;
                break;
            end
            eng_done = m_busy;
            tick();
            eng_done = '0;
        end
        n_checks++;
        if (!done_ok || busy !== 1'b0) $display("FAIL drain_timeout busy=%0b level=%0d exp busy=0", busy, fifo_level);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (fifo_level !== '0) $display("FAIL rst_level got=%0d exp=0", fifo_level); else n_pass++;
        n_checks++; if (instr_ready !== 1'b1) $display("FAIL rst_ready got=%0b exp=1", instr_ready); else n_pass++;
        n_checks++; if ({eng_start, eng_busy, busy, err_illegal} !== '0)
            $display("FAIL rst_ctrl got=%0h exp=0", {eng_start, eng_busy, busy, err_illegal}); else n_pass++;
        n_checks++; if ({eng_mode, eng_arg} !== '0 || eng_base !== '0)
            $display("FAIL rst_regs got_mode_arg=%0h exp=0", {eng_mode, eng_arg}); else n_pass++;
        do_reset();
    endtask

    task automatic test_setbase_start();
        do_reset();
        instr_valid = 1'b1;
        instr = mk(0, 3'b000, 2'd1, 19'h1234);
        tick();
        instr = mk(0, 3'b001, 2'd3, 19'd5);
        tick();
        n_checks++; if (base_of(0, 1) !== 32'h1234) $display("FAIL sb_base got=%0h exp=1234", base_of(0, 1)); else n_pass++;
        n_checks++; if (eng_start !== 2'b00) $display("FAIL sb_early_start got=%0b exp=00", eng_start); else n_pass++;
        instr_valid = 1'b0;
        tick();
        n_checks++; if (eng_start !== 2'b01) $display("FAIL st_pulse got=%0b exp=01", eng_start); else n_pass++;
        n_checks++; if (eng_mode[1:0] !== 2'd3 || eng_arg[18:0] !== 19'd5)
            $display("FAIL st_mode_arg got=%0d/%0d exp=3/5", eng_mode[1:0], eng_arg[18:0]); else n_pass++;
        tick();
        n_checks++; if (eng_start !== 2'b00 || eng_busy !== 2'b01)
            $display("FAIL st_hold got start=%0b busy=%0b exp 00/01", eng_start, eng_busy); else n_pass++;
        repeat (3) tick();
        n_checks++; if (eng_busy !== 2'b01 || busy !== 1'b1) $display("FAIL st_busy got=%0b exp=01", eng_busy); else n_pass++;
        eng_done = 2'b01;
        tick();
        eng_done = '0;
        n_checks++; if (eng_busy !== 2'b00 || busy !== 1'b0) $display("FAIL st_done got=%0b exp=00", eng_busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        do_reset();
        instr_valid = 1'b1;
        instr = mk(0, 3'b001, 2'd0, 19'd1); tick();
        instr = mk(0, 3'b001, 2'd1, 19'd2); tick();
        n_checks++; if (eng_start !== 2'b01) $display("FAIL b2b_first got=%0b exp=01", eng_start); else n_pass++;
        instr = mk(1, 3'b001, 2'd2, 19'd3); tick();
        instr_valid = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 5; i++) begin
            c0 += int'(eng_start[0]);
            c1 += int'(eng_start[1]);
            tick();
        end
        n_checks++; if (c0 != 0 || c1 != 0) $display("FAIL b2b_stall got starts=%0d/%0d exp=0/0", c0, c1); else n_pass++;
        n_checks++; if (fifo_level !== LVL_W'(2)) $display("FAIL b2b_level got=%0d exp=2", fifo_level); else n_pass++;
        eng_done = 2'b01; tick(); eng_done = '0;
        n_checks++; if (eng_busy !== 2'b00 || eng_start !== 2'b00)
            $display("FAIL b2b_release got busy=%0b start=%0b exp 00/00", eng_busy, eng_start); else n_pass++;
        tick();
        n_checks++; if (eng_start !== 2'b01 || eng_arg[18:0] !== 19'd2 || fifo_level !== LVL_W'(1))
            $display("FAIL b2b_second got start=%0b arg=%0d lvl=%0d exp 01/2/1", eng_start, eng_arg[18:0], fifo_level); else n_pass++;
        tick();
        n_checks++; if (eng_start !== 2'b10 || eng_mode[3:2] !== 2'd2 || eng_arg[37:19] !== 19'd3)
            $display("FAIL b2b_e1 got start=%0b mode=%0d arg=%0d exp 10/2/3", eng_start, eng_mode[3:2], eng_arg[37:19]); else n_pass++;
        n_checks++; if (eng_busy !== 2'b11 || fifo_level !== '0)
            $display("FAIL b2b_end got busy=%0b lvl=%0d exp 11/0", eng_busy, fifo_level); else n_pass++;
        drain();
    endtask

    task automatic test_fifo_full();
        do_reset();
        instr_valid = 1'b1;
        instr = mk(0, 3'b001, 2'd0, 19'd0); tick();
        for (int i = 0; i < 4; i++) begin
            instr = mk(0, 3'b001, 2'd0, 19'(10 + i));
            tick();
        end
        n_checks++; if (instr_ready !== 1'b0 || fifo_level !== LVL_W'(4))
            $display("FAIL full_after4 got rdy=%0b lvl=%0d exp 0/4", instr_ready, fifo_level); else n_pass++;
        instr = mk(0, 3'b001, 2'd0, 19'd14);
        repeat (3) tick();
        n_checks++; if (instr_ready !== 1'b0 || fifo_level !== LVL_W'(4))
            $display("FAIL full_hold got rdy=%0b lvl=%0d exp 0/4", instr_ready, fifo_level); else n_pass++;
        eng_done = 2'b01; tick(); eng_done = '0;
        n_checks++; if (fifo_level !== LVL_W'(4)) $display("FAIL full_done_lvl got=%0d exp=4", fifo_level); else n_pass++;
        tick();
        n_checks++; if (instr_ready !== 1'b1 || fifo_level !== LVL_W'(3) || eng_start !== 2'b01)
            $display("FAIL full_pop got rdy=%0b lvl=%0d start=%0b exp 1/3/01", instr_ready, fifo_level, eng_start); else n_pass++;
        tick();
        instr_valid = 1'b0;
        n_checks++; if (fifo_level !== LVL_W'(4)) $display("FAIL full_fifth got lvl=%0d exp=4", fifo_level); else n_pass++;
        drain();
        n_checks++; if (eng_arg[18:0] !== 19'd14) $display("FAIL full_last_arg got=%0d exp=14", eng_arg[18:0]); else n_pass++;
    endtask

    task automatic test_fence();
        do_reset();
        instr_valid = 1'b1;
        instr = mk(1, 3'b001, 2'd0, 19'd9); tick();
        instr = mk(0, 3'b010, 2'd0, 19'd0); tick();
        instr = mk(0, 3'b000, 2'd0, 19'd7); tick();
        instr_valid = 1'b0;
        repeat (4) tick();
        n_checks++; if (base_of(0, 0) !== '0 || fifo_level !== LVL_W'(2))
            $display("FAIL fence_wait got base=%0h lvl=%0d exp 0/2", base_of(0, 0), fifo_level); else n_pass++;
        eng_done = 2'b10; tick(); eng_done = '0;
        n_checks++; if (base_of(0, 0) !== '0 || fifo_level !== LVL_W'(2))
            $display("FAIL fence_d0 got base=%0h lvl=%0d exp 0/2", base_of(0, 0), fifo_level); else n_pass++;
        tick();
        n_checks++; if (base_of(0, 0) !== '0 || fifo_level !== LVL_W'(1))
            $display("FAIL fence_d1 got base=%0h lvl=%0d exp 0/1", base_of(0, 0), fifo_level); else n_pass++;
        tick();
        n_checks++; if (base_of(0, 0) !== 32'd7 || fifo_level !== '0)
            $display("FAIL fence_d2 got base=%0h lvl=%0d exp 7/0", base_of(0, 0), fifo_level); else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        instr_valid = 1'b1;
        instr = mk(NUM_ENG, 3'b001, 2'd0, 19'd1); tick();
        instr = mk(0, 3'b111, 2'd0, 19'd2); tick();
        n_checks++; if (err_illegal !== 1'b1) $display("FAIL ill_opc got=%0b exp=1", err_illegal); else n_pass++;
        instr_valid = 1'b0;
        tick();
        n_checks++; if (fifo_level !== '0 || eng_start !== '0 || eng_busy !== '0 || err_illegal !== 1'b1)
            $display("FAIL ill_func got lvl=%0d start=%0b busy=%0b err=%0b exp 0/0/0/1", fifo_level, eng_start, eng_busy, err_illegal); else n_pass++;
        instr_valid = 1'b1;
        instr = mk(-1, 3'b101, 2'd0, 19'd3); tick();
        instr_valid = 1'b0;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_checks++; if (err_illegal !== 1'b1) $display("FAIL ill_set_wins got=%0b exp=1", err_illegal); else n_pass++;
        tick();
        n_checks++; if (err_illegal !== 1'b1) $display("FAIL ill_sticky got=%0b exp=1", err_illegal); else n_pass++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_checks++; if (err_illegal !== 1'b0) $display("FAIL ill_clr got=%0b exp=0", err_illegal); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_valid = 1'b1;
        instr = mk(1, 3'b000, 2'd2, 19'h55); tick();
        instr = mk(0, 3'b001, 2'd1, 19'd1); tick();
        instr = mk(1, 3'b001, 2'd2, 19'd2); tick();
        instr = mk(0, 3'b001, 2'd0, 19'd3); tick();
        instr = mk(0, 3'b001, 2'd0, 19'd4); tick();
        instr = mk(0, 3'b000, 2'd0, 19'd5); tick();
        instr_valid = 1'b0;
        n_checks++; if (fifo_level !== LVL_W'(3) || eng_busy !== 2'b11 || base_of(1, 2) !== 32'h55)
            $display("FAIL mid_setup got lvl=%0d busy=%0b base=%0h exp 3/11/55", fifo_level, eng_busy, base_of(1, 2)); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({eng_start, eng_busy, busy, err_illegal, fifo_level} !== '0 || instr_ready !== 1'b1)
            $display("FAIL mid_rst_ctrl got=%0h rdy=%0b exp 0/1", {eng_start, eng_busy, busy, err_illegal, fifo_level}, instr_ready); else n_pass++;
        n_checks++; if ({eng_mode, eng_arg} !== '0 || eng_base !== '0)
            $display("FAIL mid_rst_regs got=%0h exp=0", {eng_mode, eng_arg}); else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        eng_done = 2'b11; tick(); eng_done = '0;
        n_checks++; if (eng_busy !== '0 || eng_start !== '0 || busy !== 1'b0 || instr_ready !== 1'b1)
            $display("FAIL mid_stale_done got busy=%0b start=%0b exp 00/00", eng_busy, eng_start); else n_pass++;
    endtask

    function automatic logic [31:0] rand_word();
        int r, e;
        logic [2:0] f;
        logic [31:0] w;
        r = int'($urandom_range(9));
        if (r < 4) e = 0;
        else if (r < 7) e = 1;
        else if (r == 7) e = NUM_ENG;
        else if (r == 8) e = -1;
        else e = int'($urandom_range(127)) - int'(OPC_BASE);
        r = int'($urandom_range(9));
        if (r < 3) f = 3'b000;
        else if (r < 7) f = 3'b001;
        else if (r < 9) f = 3'b010;
        else f = 3'($urandom_range(7));
        w = mk(e, f, 2'($urandom_range(3)), 19'($urandom));
        w[31] = 1'($urandom_range(1));
        return w;
    endfunction

    task automatic test_random();
        bit hold;
        logic [NUM_ENG*2-1:0]  x_mode;
        logic [NUM_ENG*19-1:0] x_arg;
        logic [NUM_ENG*NUM_BASE*ADDR_W-1:0] x_base;
        do_reset();
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!hold) begin
                instr_valid = ($urandom_range(3) != 0);
                instr = rand_word();
            end
            for (int e = 0; e < NUM_ENG; e++) eng_done[e] = ($urandom_range(3) == 0);
            err_clr = ($urandom_range(15) == 0);
            hold = instr_valid && (m_q.size() >= FIFO_DEPTH);
            tick();
            for (int e = 0; e < NUM_ENG; e++) begin
                x_mode[2*e +: 2]  = m_mode[e];
                x_arg[19*e +: 19] = m_arg[e];
                for (int s = 0; s < NUM_BASE; s++) x_base[(e*NUM_BASE+s)*ADDR_W +: ADDR_W] = m_base[e][s];
            end
            n_checks++; if (fifo_level !== LVL_W'(m_q.size()))
                $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, m_q.size()); else n_pass++;
            n_checks++; if (instr_ready !== (m_q.size() < FIFO_DEPTH))
                $display("FAIL rnd_ready cyc=%0d got=%0b", cyc, instr_ready); else n_pass++;
            n_checks++; if (eng_start !== m_start || eng_busy !== m_busy)
                $display("FAIL rnd_eng cyc=%0d got start=%0b busy=%0b exp %0b/%0b", cyc, eng_start, eng_busy, m_start, m_busy); else n_pass++;
            n_checks++; if (busy !== (m_q.size() != 0 || m_busy != '0) || err_illegal !== m_err)
                $display("FAIL rnd_flags cyc=%0d got busy=%0b err=%0b exp err=%0b", cyc, busy, err_illegal, m_err); else n_pass++;
            n_checks++; if (eng_mode !== x_mode || eng_arg !== x_arg)
                $display("FAIL rnd_mode_arg cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, eng_mode, eng_arg, x_mode, x_arg); else n_pass++;
            n_checks++; if (eng_base !== x_base)
                $display("FAIL rnd_base cyc=%0d got=%0h exp=%0h", cyc, eng_base, x_base); else n_pass++;
        end
        eng_done = '0;
        err_clr  = 1'b0;
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_setbase_start();
        test_back_to_back();
        test_fifo_full();
        test_fence();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/face_cmd_dispatcher.md
Name: face_cmd_dispatcher

Overview:
Parametrised instruction front-end for the Frodo acceleration engine. Replaces the level-held instruction decode with a valid/ready instruction FIFO. Owns per-engine base-address registers and dispatches START commands in order to NUM_ENG engines (e.g. systolic multiplier, SHAKE core). Tracks per-engine busy state, supports FENCE and config-hazard stalls, and flags illegal instructions.

Parameters:
FIFO_DEPTH, 4, instruction FIFO entries; power of 2, at least 2
NUM_ENG, 2, number of engines; 1..8
NUM_BASE, 4, base-address registers per engine; 1..4
ADDR_W, 32, base-address width; at least 19
OPC_BASE, 7'h0B, opcode of engine 0; engine e uses OPC_BASE+e

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr  in  32  instruction word
instr_ready  out  1  FIFO can accept; equals !full
eng_start  out  NUM_ENG  one-cycle start pulse per engine
eng_mode  out  NUM_ENG*2  per-engine mode (instr[11:10]), latched at START
eng_arg  out  NUM_ENG*19  per-engine argument (instr[30:12]), latched at START
eng_base  out  NUM_ENG*NUM_BASE*ADDR_W  base-address registers, flattened, engine-major
eng_done  in  NUM_ENG  one-cycle completion pulse from each engine
eng_busy  out  NUM_ENG  engine has an outstanding START
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
busy  out  1  fifo_level!=0 or any eng_busy
err_illegal  out  1  sticky illegal-instruction flag
err_clr  in  1  clears err_illegal

Behaviour:
- Reset: asynchronous. FIFO emptied. All outputs 0: eng_start, eng_busy, eng_mode, eng_arg, eng_base, err_illegal, busy, fifo_level. instr_ready=1 after reset. Reset mid-operation aborts everything; eng_done pulses for work started before reset are ignored because eng_busy=0.
- Decode fields: opcode instr[6:0], func instr[9:7], sel instr[11:10], payload instr[30:12]. Engine index e = opcode-OPC_BASE. The opcode is legal only if 0<=e<NUM_ENG.
- Push: on an edge where instr_valid && instr_ready, the word is written. No same-cycle bypass. A push while full is impossible because ready=0.
- The head is examined combinationally each cycle while the FIFO is non-empty. Commands execute strictly in order; a blocked head stalls all entries behind it.
- func 3'b000 SETBASE:
  - Stalls while eng_busy[e].
  - Otherwise, at the next edge: eng_base[e][sel] <= zero-extended payload, then pop.
  - sel>=NUM_BASE is illegal.
- func 3'b001 START:
  - Stalls while eng_busy[e].
  - Otherwise, at the next edge: pop; eng_start[e]<=1 for exactly one cycle; eng_busy[e]<=1; eng_mode[e]<=sel; eng_arg[e]<=payload.
  - eng_mode and eng_arg hold until the next START to that engine.
- func 3'b010 FENCE: pops only on a cycle where all eng_busy=0 and eng_start=0.
- Any other func, or an illegal opcode or sel: pop in 1 cycle with no side effect, and err_illegal<=1.
- err_clr clears err_illegal. If an illegal pop and err_clr occur on the same edge, set wins.
- eng_done[e] clears eng_busy[e] at the next edge.
  - eng_done[e] while eng_busy[e]=0 is ignored.
  - eng_done[e] and a START pop for engine e cannot coincide, because START stalls while busy. A START to e may pop on the edge after eng_busy[e] falls.
- At most one pop per cycle. Push and pop on the same edge leave fifo_level unchanged.
- Latency: a word pushed at edge k is at the head after k. With no stall it pops at edge k+1, and eng_start is high in the cycle after edge k+1. Sustained throughput is 1 command per cycle.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_level.
- busy is combinational from fifo_level and eng_busy.

Test Plan:
1. SETBASE e=0 sel=1 payload=19'h1234, then START e=0 sel=3 payload=5 -> eng_base[0][1]=32'h1234; eng_start[0] pulses 1 cycle, 2 edges after the START push; eng_mode[0]=3, eng_arg[0]=5, eng_busy[0]=1 until the edge after eng_done[0].
2. Back-to-back START e0, START e0, START e1 with eng_done held low -> only one eng_start[0] pulse; queue stalls with level=2; e1 does not start (in-order). Pulse eng_done[0] -> second e0 start, then e1 start on the following edge.
3. Push 5 words with FIFO_DEPTH=4 and engine 0 busy -> instr_ready=0 after the 4th push, fifo_level=4; the 5th word is held by the source and accepted after the first pop.
4. START e1, FENCE, SETBASE e0 sel=0 payload=7 -> SETBASE is not applied until eng_done[1]; it is applied 2 edges after the done pulse.
5. opcode OPC_BASE+NUM_ENG, then func 3'b111 -> both pop, err_illegal=1 and stays set; err_clr asserted on the same edge as a further illegal pop -> err_illegal remains 1; a later lone err_clr -> 0.
6. Assert rst_n=0 mid-run with 3 queued words and eng_busy=2'b11 -> all outputs 0 immediately; a stale eng_done after reset has no effect; instr_ready=1.
